rx_demux: RTL and testbench
===========================

RX_DEMUX -- requirements
Module: rx_demux

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 rdata  input  8  rx fifo read data, first-word-fall-through, valid while rempty low.
REQ-005 rempty  input  1  rx fifo empty, active high.
REQ-006 rinc  output  1  rx fifo read increment, active high, one pop per cycle asserted.
REQ-007 out_0, out_1, out_2, out_3  output  16 each  per-channel received word.
REQ-008 valid  output  4  per-channel word-valid, active high.
REQ-009 ack  input  4  per-channel consumer acknowledge, active high.
REQ-010 err  output  1  one-cycle pulse on malformed header byte.
REQ-011 err_cnt  output  8  count of malformed header bytes, saturating.

Function
REQ-012 Frame format SHALL be three bytes in order: header, MSB, LSB; header[1:0] = channel, header[7:2] = 6'b000000.
REQ-013 States SHALL be HDR, MSB, LSB, DELIVER; reset state HDR.
REQ-014 rinc SHALL be combinational: high iff state in {HDR, MSB, LSB} and rempty low; never high in DELIVER.
REQ-015 HDR: on rinc with rdata[7:2] == 0, latch ch = rdata[1:0], go MSB.
REQ-016 HDR: on rinc with rdata[7:2] != 0, discard byte, pulse err next cycle, increment err_cnt (hold at 8'hFF), remain HDR.
REQ-017 MSB: on rinc, latch word[15:8] = rdata, go LSB; rempty high -> wait, no timeout.
REQ-018 LSB: on rinc, latch word[7:0] = rdata, go DELIVER.
REQ-019 DELIVER: if valid[ch] low or ack[ch] high this cycle, load out_ch = word, set valid[ch], go HDR; else hold DELIVER (backpressure, no pops).
REQ-020 valid[n] SHALL clear on the edge where ack[n] is sampled high, unless the same edge loads channel n (load wins, valid[n] stays 1, out_n updated).
REQ-021 ack[n] while valid[n] low SHALL be ignored.
REQ-022 out_n SHALL hold its value until the next load of channel n; not cleared by ack.
REQ-023 Channels other than ch SHALL be unaffected by a delivery; acks on other channels processed in parallel.
REQ-024 Latency: with fifo non-empty, header popped cycle 0, MSB cycle 1, LSB cycle 2, DELIVER cycle 3, valid[ch] high from cycle 4 (free channel).
REQ-025 Back-to-back frames: next header SHALL be popped in the cycle after DELIVER completes (4 cycles per frame minimum).

Reset
REQ-026 rst_n low SHALL immediately force state HDR, valid 4'h0, out_0..out_3 16'h0000, err 0, err_cnt 8'h00, internal word/ch 0; rinc follows REQ-014 from HDR.
REQ-027 Reset mid-frame SHALL abandon the partial frame; bytes already popped are lost; the first byte after release is treated as header.

Verification
REQ-028 Fifo holds 02,AB,CD, ack low -> rinc high 3 consecutive cycles, valid = 4'b0100 on 5th cycle, out_2 = 16'hABCD, other outputs 0.
REQ-029 valid[1] high unacked, frame 01,12,34 arrives -> FSM holds DELIVER, rinc low, out_1 unchanged; ack[1] pulse -> out_1 = 16'h1234, valid[1] stays 1.
REQ-030 Bytes 80,03,00,07 -> err pulse once, err_cnt = 1, 80 discarded, then out_3 = 16'h0007, valid[3] high.
REQ-031 rempty toggled high between each byte of 00,FF,01 -> no pops while empty, out_0 = 16'hFF01 delivered once.
REQ-032 rst_n low after MSB pop of frame 01,55,.. -> all outputs zero; after release bytes 00,11,22 -> out_0 = 16'h1122, out_1 remains 0.
REQ-033 256+ malformed headers (FC) -> err_cnt saturates at 8'hFF, err still pulses per byte.

Source files
------------

// File: rtl/rx_demux_if.sv
// rtl/rx_demux_if.sv - rx fifo, per-channel output and error signals of rx_demux
interface rx_demux_if;
    logic [7:0]  rdata;
    logic        rempty;
    logic        rinc;
    logic [15:0] out_0;
    logic [15:0] out_1;
    logic [15:0] out_2;
    logic [15:0] out_3;
    logic [3:0]  valid;
    logic [3:0]  ack;
    logic        err;
    logic [7:0]  err_cnt;

    modport master (
        input  rdata, rempty, ack,
        output rinc, out_0, out_1, out_2, out_3, valid, err, err_cnt
    );

    modport slave (
        output rdata, rempty, ack,
        input  rinc, out_0, out_1, out_2, out_3, valid, err, err_cnt
    );
endinterface

// File: rtl/rx_demux.sv
// rtl/rx_demux.sv - splits 3-byte header/MSB/LSB frames from an rx fifo onto four word channels
module rx_demux (
    input  logic       clk,
    input  logic       rst_n,
    rx_demux_if.master bus
);
    typedef enum logic [1:0] {HDR, MSB, LSB, DELIVER} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  ch;
    logic [15:0] word;
    logic [15:0] out_r [4];
    logic [3:0]  valid_r;
    logic        err_r;
    logic [7:0]  err_cnt_r;

    logic        pop;
    logic        hdr_ok;
    logic        hdr_bad;
    logic        load;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        hdr_ok    = 1'b0;
        hdr_bad   = 1'b0;
        load      = 1'b0;
        case (state)
            HDR: begin
                if (!bus.rempty) begin
                    pop = 1'b1;
                    if (bus.rdata[7:2] == 6'd0) begin
                        hdr_ok    = 1'b1;
                        state_nxt = MSB;
                    end else begin
                        hdr_bad = 1'b1;
                    end
                end
            end
            MSB: begin
                if (!bus.rempty) begin
                    pop       = 1'b1;
                    state_nxt = LSB;
                end
            end
            LSB: begin
                if (!bus.rempty) begin
                    pop       = 1'b1;
                    state_nxt = DELIVER;
                end
            end
            DELIVER: begin
                // a same-cycle ack frees the slot, so the new word can replace the old one
                if (!valid_r[ch] || bus.ack[ch]) begin
                    load      = 1'b1;
                    state_nxt = HDR;
                end
            end
            default: state_nxt = HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HDR;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch        <= 2'd0;
            word      <= 16'h0000;
            valid_r   <= 4'h0;
            err_r     <= 1'b0;
            err_cnt_r <= 8'h00;
            for (int n = 0; n < 4; n++) begin
                out_r[n] <= 16'h0000;
            end
        end else begin
            if (hdr_ok) begin
                ch <= bus.rdata[1:0];
            end
            if (state == MSB && pop) begin
                word[15:8] <= bus.rdata;
            end
            if (state == LSB && pop) begin
                word[7:0] <= bus.rdata;
            end
            err_r <= hdr_bad;
            if (hdr_bad && err_cnt_r != 8'hFF) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end
            for (int n = 0; n < 4; n++) begin
                if (load && ch == 2'(n)) begin
                    valid_r[n] <= 1'b1;
                    out_r[n]   <= word;
                end else if (bus.ack[n]) begin
                    valid_r[n] <= 1'b0;
                end
            end
        end
    end

    assign bus.rinc    = pop;
    assign bus.out_0   = out_r[0];
    assign bus.out_1   = out_r[1];
    assign bus.out_2   = out_r[2];
    assign bus.out_3   = out_r[3];
    assign bus.valid   = valid_r;
    assign bus.err     = err_r;
    assign bus.err_cnt = err_cnt_r;
endmodule

// File: tb/tb_rx_demux.sv
// tb/tb_rx_demux.sv - directed and randomized checks of rx_demux against a frame-level model
module tb_rx_demux;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rx_demux_if bus ();
    rx_demux dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  fifo_q [$];
    logic [15:0] exp_q [4][$];
    logic        auto_ack;
    int          ack_pct;
    int          stall_pct;
    logic [3:0]  man_ack;
    logic        force_empty;
    logic        s_rinc;
    logic        s_err;
    logic [3:0]  s_valid;
    logic [15:0] s_out [4];
    logic [7:0]  s_err_cnt;
    int          err_seen;
    int          pops;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: snapshot outputs at the falling edge, drive inputs, then let the rising edge pop.
    task automatic tick();
        logic [3:0] a;
        @(negedge clk);
        s_valid   = bus.valid;
        s_out[0]  = bus.out_0;
        s_out[1]  = bus.out_1;
        s_out[2]  = bus.out_2;
        s_out[3]  = bus.out_3;
        s_err     = bus.err;
        s_err_cnt = bus.err_cnt;
        a = man_ack;
        if (auto_ack) begin
            for (int n = 0; n < 4; n++) begin
                a[n] = s_valid[n] && ($urandom_range(0, 99) < ack_pct);
                if (a[n]) begin
                    chk($sformatf("word_pending_ch%0d", n), 32'(exp_q[n].size() != 0), 32'd1);
                    if (exp_q[n].size() != 0)
                        chk($sformatf("word_ch%0d", n), 32'(s_out[n]), 32'(exp_q[n].pop_front()));
                end
            end
        end
        bus.ack    = a;
        bus.rempty = force_empty || ($urandom_range(0, 99) < stall_pct) || (fifo_q.size() == 0);
        bus.rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        #1;
        s_rinc = bus.rinc;
        chk("no_pop_while_empty", 32'(s_rinc & bus.rempty), 32'd0);
        if (s_err) err_seen++;
        @(posedge clk);
        if (s_rinc && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
            pops++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        bus.ack    = 4'h0;
        bus.rempty = 1'b1;
        bus.rdata  = 8'h00;
        fifo_q.delete();
        for (int n = 0; n < 4; n++) exp_q[n].delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [4:0]  rh;
        logic [3:0]  vh [5];
        logic [7:0]  h;
        logic [1:0]  c;
        logic [15:0] w;
        int          bad;
        int          budget;

        rst_n = 1'b0; auto_ack = 1'b0; man_ack = 4'h0; ack_pct = 0; stall_pct = 0;
        force_empty = 1'b0; err_seen = 0; pops = 0;
        bus.ack = 4'h0; bus.rempty = 1'b1; bus.rdata = 8'h00;
        do_reset();

        tick();
        chk("rst_rinc", 32'(s_rinc), 32'd0);
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_out01", {s_out[0], s_out[1]}, 32'd0);
        chk("rst_out23", {s_out[2], s_out[3]}, 32'd0);
        chk("rst_err", 32'(s_err), 32'd0);
        chk("rst_err_cnt", 32'(s_err_cnt), 32'd0);

        // single frame to channel 2, latency
        fifo_q = '{8'h02, 8'hAB, 8'hCD};
        for (int k = 0; k < 5; k++) begin
            tick();
            rh[k] = s_rinc;
            vh[k] = s_valid;
        end
        chk("f1_rinc_seq", 32'(rh), 32'h07);
        chk("f1_valid_c3", 32'(vh[3]), 32'h0);
        chk("f1_valid_c4", 32'(vh[4]), 32'h4);
        chk("f1_out2", 32'(s_out[2]), 32'hABCD);
        chk("f1_out013", {s_out[0] | s_out[1], s_out[3]}, 32'd0);

        // backpressure on channel 1
        fifo_q = '{8'h01, 8'h99, 8'h88};
        for (int k = 0; k < 5; k++) tick();
        chk("bp_valid_first", 32'(s_valid), 32'h6);
        chk("bp_out1_first", 32'(s_out[1]), 32'h9988);
        fifo_q = '{8'h01, 8'h12, 8'h34, 8'h00, 8'hAA, 8'hBB};
        rh = 5'd0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k < 5) rh[k] = s_rinc;
        end
        chk("bp_rinc_seq", 32'(rh), 32'h07);
        chk("bp_hold_rinc", 32'(s_rinc), 32'd0);
        chk("bp_hold_out1", 32'(s_out[1]), 32'h9988);
        man_ack = 4'b0010;
        tick();
        man_ack = 4'b0000;
        tick();
        chk("bp_load_out1", 32'(s_out[1]), 32'h1234);
        chk("bp_load_valid1", 32'(s_valid[1]), 32'd1);
        for (int k = 0; k < 5; k++) tick();
        chk("bp_next_valid", 32'(s_valid), 32'h7);
        chk("bp_next_out0", 32'(s_out[0]), 32'hAABB);
        man_ack = 4'b0110;
        tick();
        man_ack = 4'b0000;
        tick();
        chk("ack_clear_valid", 32'(s_valid), 32'h1);
        chk("ack_keeps_out", {s_out[1], s_out[2]}, 32'h1234ABCD);
        man_ack = 4'b0001;
        tick();
        man_ack = 4'b0000;

        // malformed header then frame to channel 3
        err_seen = 0;
        fifo_q = '{8'h80, 8'h03, 8'h00, 8'h07};
        for (int k = 0; k < 8; k++) tick();
        chk("bad_err_pulses", 32'(err_seen), 32'd1);
        chk("bad_err_cnt", 32'(s_err_cnt), 32'd1);
        chk("bad_out3", 32'(s_out[3]), 32'h0007);
        chk("bad_valid", 32'(s_valid), 32'h8);
        man_ack = 4'b1000;
        tick();
        man_ack = 4'b0000;

        // fifo empties between every byte
        pops = 0;
        fifo_q = '{8'h00, 8'hFF, 8'h01};
        for (int k = 0; k < 12; k++) begin
            force_empty = (k % 2 == 0);
            tick();
        end
        force_empty = 1'b0;
        chk("gap_pops", 32'(pops), 32'd3);
        chk("gap_out0", 32'(s_out[0]), 32'hFF01);
        chk("gap_valid", 32'(s_valid), 32'h1);

        // reset in the middle of a frame
        fifo_q = '{8'h01, 8'h55, 8'h66};
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.valid), 32'd0);
        chk("midrst_out0", 32'(bus.out_0), 32'd0);
        chk("midrst_err_cnt", 32'(bus.err_cnt), 32'd0);
        fifo_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        fifo_q = '{8'h00, 8'h11, 8'h22};
        for (int k = 0; k < 6; k++) tick();
        chk("postrst_out0", 32'(s_out[0]), 32'h1122);
        chk("postrst_out1", 32'(s_out[1]), 32'd0);
        chk("postrst_valid", 32'(s_valid), 32'h1);

        // error counter saturation
        err_seen = 0;
        for (int k = 0; k < 260; k++) fifo_q.push_back(8'hFC);
        for (int k = 0; k < 263; k++) tick();
        chk("sat_err_pulses", 32'(err_seen), 32'd260);
        chk("sat_err_cnt", 32'(s_err_cnt), 32'hFF);

        // random frames, random stalls and random consumer acks
        do_reset();
        err_seen = 0;
        bad = 0;
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                h = 8'($urandom_range(4, 255));
                fifo_q.push_back(h);
                bad++;
            end else begin
                c = 2'($urandom_range(0, 3));
                w = 16'($urandom);
                fifo_q.push_back({6'd0, c});
                fifo_q.push_back(w[15:8]);
                fifo_q.push_back(w[7:0]);
                exp_q[c].push_back(w);
            end
        end
        auto_ack = 1'b1; ack_pct = 40; stall_pct = 25;
        budget = 20000;
        while ((fifo_q.size() != 0 || exp_q[0].size() != 0 || exp_q[1].size() != 0 ||
                exp_q[2].size() != 0 || exp_q[3].size() != 0) && budget > 0) begin
            tick();
            budget--;
        end
        chk("rand_done_in_budget", 32'(budget > 0), 32'd1);
        for (int k = 0; k < 3; k++) tick();
        chk("rand_err_pulses", 32'(err_seen), 32'(bad));
        chk("rand_err_cnt", 32'(s_err_cnt), 32'(bad > 255 ? 255 : bad));
        chk("rand_all_consumed", 32'(s_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
